// File: rtl/mfp_ahb_uart.sv
// AHB-lite 8N1 UART: TX FIFO, 1-deep RX holding register, DATA/STAT/DIV/CTRL registers.
// Optional internal loopback (CTRL[0]) is built when MFP_UART_LOOPBACK_EN is defined.
module mfp_ahb_uart #(
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned DEFAULT_DIV = 433
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        IO_UART_TX,
  input  logic        IO_UART_RX
);

  localparam int unsigned AW = $clog2(TX_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic          accept, rd_data, rd_stat;
  logic          wr_pend;
  logic [1:0]    wr_addr;
  logic [15:0]   div;
  logic          loop;
  logic [7:0]    rx_byte;
  logic          rx_valid, overrun, frame_err;
  logic [31:0]   stat;

  logic [7:0]    fifo [TX_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          push, pop;

  tx_state_t     tx_state;
  logic [15:0]   tx_cnt, tx_div;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic          tx_ser, tx_busy, tx_bit_end;

  rx_state_t     rx_state;
  logic          rx_in, rx_m, rx_s, rx_prev;
  logic [15:0]   rx_cnt, rx_div;
  logic [16:0]   rx_half;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_done, rx_ferr;

  logic          unused;
  assign unused = &{1'b0, HWDATA[31:16], HTRANS[0]};

  assign accept  = HSEL & HTRANS[1];
  assign rd_data = accept & ~HWRITE & (HADDR == 2'd0);
  assign rd_stat = accept & ~HWRITE & (HADDR == 2'd1);
  assign tx_busy = (tx_state != TX_IDLE);
  assign stat    = {26'b0, frame_err, overrun, tx_busy, rx_valid,
                    count == CW'(0), count == CW'(TX_DEPTH)};

  // A push to a full FIFO only lands when the engine pops in the same cycle
  assign push = wr_pend && (wr_addr == 2'd0) && ((count != CW'(TX_DEPTH)) || pop);
  assign tx_bit_end = (tx_cnt == tx_div);
  assign pop = (count != CW'(0)) &&
               ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end));

`ifdef MFP_UART_LOOPBACK_EN
  assign rx_in = loop ? tx_ser : IO_UART_RX;
`else
  assign loop  = 1'b0;
  assign rx_in = IO_UART_RX;
`endif
  assign IO_UART_TX = tx_ser | loop;

  // Bus registers, read mux and RX status flags
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HRDATA    <= 32'b0;
      wr_pend   <= 1'b0;
      wr_addr   <= 2'd0;
      div       <= 16'(DEFAULT_DIV);
      rx_byte   <= 8'b0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
`ifdef MFP_UART_LOOPBACK_EN
      loop      <= 1'b0;
`endif
    end else begin
      wr_pend <= accept & HWRITE;
      wr_addr <= HADDR;
      if (accept && !HWRITE) begin
        case (HADDR)
          2'd0:    HRDATA <= {24'b0, rx_byte};
          2'd1:    HRDATA <= stat;
          2'd2:    HRDATA <= {16'b0, div};
          default: HRDATA <= {31'b0, loop};
        endcase
      end
      if (wr_pend && wr_addr == 2'd2) div <= HWDATA[15:0];
`ifdef MFP_UART_LOOPBACK_EN
      if (wr_pend && wr_addr == 2'd3) loop <= HWDATA[0];
`endif
      if (rd_stat) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (rd_data) rx_valid <= 1'b0;
      // Delivery after the clears so that a same-cycle set wins
      if (rx_done) begin
        if (!rx_valid || rd_data) begin
          rx_byte  <= rx_sh;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end
      if (rx_ferr) frame_err <= 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) fifo[wptr] <= HWDATA[7:0];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // TX engine: each bit lasts tx_div+1 cycles, divisor latched per frame
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_div   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_sh    <= 8'd0;
      tx_ser   <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (pop) begin
            tx_state <= TX_START;
            tx_div   <= div;
            tx_sh    <= fifo[rptr];
            tx_cnt   <= 16'd0;
            tx_ser   <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_state <= TX_DATA;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_ser   <= tx_sh[0];
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= 16'd0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              tx_ser   <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx_ser <= tx_sh[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: begin
          if (tx_bit_end) begin
            tx_cnt <= 16'd0;
            if (pop) begin
              tx_state <= TX_START;
              tx_div   <= div;
              tx_sh    <= fifo[rptr];
              tx_ser   <= 1'b0;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx_in;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  assign rx_half = (17'(rx_div) + 17'd1) >> 1;

  // RX engine: mid-start check rejects glitches, then samples at bit-period spacing
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_div   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'd0;
      rx_done  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= RX_START;
            rx_cnt   <= 16'd0;
            rx_div   <= div;
          end
        end
        RX_START: begin
          if ((17'(rx_cnt) + 17'd1) >= rx_half) begin
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == rx_div) begin
            rx_cnt <= 16'd0;
            rx_sh  <= {rx_s, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: begin
          if (rx_cnt == rx_div) begin
            rx_cnt   <= 16'd0;
            rx_state <= RX_IDLE;
            if (rx_s) rx_done <= 1'b1;
            else      rx_ferr <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_ahb_uart.sv
// Self-checking bench for mfp_ahb_uart: register table, directed TX/RX corners,
// and a randomized RX/TX sequence against a flag-level model.
module tb_mfp_ahb_uart;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [1:0]  HADDR = 2'd0;
  logic [1:0]  HTRANS = 2'd0;
  logic [31:0] HWDATA = 32'd0;
  logic        HWRITE = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HRDATA;
  logic        IO_UART_TX;
  logic        IO_UART_RX = 1'b1;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;

  mfp_ahb_uart dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HWRITE(HWRITE), .HSEL(HSEL), .HRDATA(HRDATA),
    .IO_UART_TX(IO_UART_TX), .IO_UART_RX(IO_UART_RX)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

`ifdef MFP_UART_LOOPBACK_EN
  localparam logic [31:0] LOOP_EXP = 32'd1;
`else
  localparam logic [31:0] LOOP_EXP = 32'd0;
`endif

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    d = HRDATA;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  // Serial frame: start 0, 8 data bits LSB first, chosen stop level, then idle
  task automatic rx_send(input logic [7:0] b, input logic stop, input int d);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(negedge HCLK);
    for (int i = 0; i < 10; i++) begin
      IO_UART_RX = f[i];
      repeat (d + 1) @(negedge HCLK);
    end
    IO_UART_RX = 1'b1;
    repeat (2 * (d + 1)) @(negedge HCLK);
  endtask

  // Wait for a start bit, sample every bit at its centre, compare the whole frame
  task automatic tx_expect(input logic [7:0] b, input int d, input string name);
    logic [9:0] got;
    int n, off, target;
    n = 0;
    got = '0;
    do begin
      @(posedge HCLK); #1;
      n++;
    end while (IO_UART_TX !== 1'b0 && n < 30 * (d + 1) + 60);
    if (IO_UART_TX !== 1'b0) begin
      tests++; fails++;
      $display("FAIL %s: no start bit within %0d cycles (line=%b)", name, n, IO_UART_TX);
    end else begin
      off = 0;
      for (int k = 0; k < 10; k++) begin
        target = k * (d + 1) + (d + 1) / 2;
        while (off < target) begin
          @(posedge HCLK); #1;
          off++;
        end
        got[k] = IO_UART_TX;
      end
      check(name, {22'b0, got}, {22'b0, 1'b1, b, 1'b0});
    end
  endtask

  task automatic count_low(input int ncyc, output int lows);
    lows = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge HCLK); #1;
      if (IO_UART_TX !== 1'b1) lows++;
    end
  endtask

  vec_t vecs[12];
  logic [7:0] fb[10];
  logic [7:0] m_byte;
  logic       m_valid, m_ovr, m_ferr;
  logic [9:0] f55;
  logic [31:0] rd;
  int unsigned e1;
  int bad, lows, d, op;
  logic [7:0] rb;
  logic rs;

  initial begin
    vecs[0]  = '{1'b0, 2'd1, 32'h0000_0002};
    vecs[1]  = '{1'b0, 2'd2, 32'd433};
    vecs[2]  = '{1'b0, 2'd3, 32'h0};
    vecs[3]  = '{1'b1, 2'd2, 32'hFFFF_0007};
    vecs[4]  = '{1'b0, 2'd2, 32'h0000_0007};
    vecs[5]  = '{1'b1, 2'd3, 32'h1};
    vecs[6]  = '{1'b0, 2'd3, LOOP_EXP};
    vecs[7]  = '{1'b1, 2'd3, 32'h0};
    vecs[8]  = '{1'b0, 2'd3, 32'h0};
    vecs[9]  = '{1'b1, 2'd2, 32'h0000_0003};
    vecs[10] = '{1'b0, 2'd2, 32'h0000_0003};
    vecs[11] = '{1'b0, 2'd1, 32'h0000_0002};

    repeat (3) @(posedge HCLK);
    @(negedge HCLK); HRESET = 1'b0;
    @(posedge HCLK); #1;
    check("reset_tx_line", {31'b0, IO_UART_TX}, 32'd1);
    check("reset_hrdata", HRDATA, 32'd0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data);
    end

    // Exact waveform of 0x55 at DIV=3
    f55 = {1'b1, 8'h55, 1'b0};
    bus_write(2'd0, 32'h55);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge HCLK); #1;
      if (IO_UART_TX !== f55[c / 4]) bad++;
    end
    check("tx_wave_55_bad_cycles", bad, 0);
    @(posedge HCLK); #1;
    check("tx_idle_after_frame", {31'b0, IO_UART_TX}, 32'd1);
    repeat (2) @(posedge HCLK);
    read_check("stat_tx_done", 2'd1, 32'h02);

    // FIFO stall: drop while full, accept when push meets pop
    for (int i = 0; i < 10; i++) fb[i] = 8'h30 + 8'(i);
    fork
      begin
        bus_write(2'd0, {24'b0, fb[0]});
        e1 = cyc;
        for (int i = 1; i < 9; i++) bus_write(2'd0, {24'b0, fb[i]});
        read_check("stat_full_busy", 2'd1, 32'h09);
        bus_write(2'd0, 32'hEE);
        while (cyc != e1 + 39) begin
          @(posedge HCLK); #1;
        end
        bus_write(2'd0, {24'b0, fb[9]});
      end
      begin
        for (int i = 0; i < 10; i++) tx_expect(fb[i], 3, $sformatf("fifo_frame%0d", i));
      end
    join
    count_low(100, lows);
    check("no_extra_frame", lows, 0);
    read_check("stat_fifo_drained", 2'd1, 32'h02);

    // RX directed
    rx_send(8'hA3, 1'b1, 3);
    read_check("rx_stat_valid", 2'd1, 32'h06);
    read_check("rx_data_a3", 2'd0, 32'hA3);
    read_check("rx_stat_popped", 2'd1, 32'h02);
    rx_send(8'h11, 1'b1, 3);
    rx_send(8'h22, 1'b1, 3);
    read_check("rx_overrun_keeps_first", 2'd0, 32'h11);
    read_check("rx_stat_overrun", 2'd1, 32'h12);
    read_check("rx_stat_overrun_cleared", 2'd1, 32'h02);
    rx_send(8'h5A, 1'b0, 3);
    read_check("rx_stat_frame_err", 2'd1, 32'h22);
    read_check("rx_stat_frame_err_cleared", 2'd1, 32'h02);
    bus_write(2'd2, 32'd7);
    @(negedge HCLK); IO_UART_RX = 1'b0;
    @(negedge HCLK); IO_UART_RX = 1'b1;
    repeat (30) @(posedge HCLK);
    read_check("rx_glitch_ignored", 2'd1, 32'h02);

    // Reset in the middle of a TX frame
    bus_write(2'd2, 32'd3);
    bus_write(2'd0, 32'hF0);
    repeat (10) @(posedge HCLK);
    @(negedge HCLK); HRESET = 1'b1;
    @(posedge HCLK); #1;
    check("rst_mid_tx_line", {31'b0, IO_UART_TX}, 32'd1);
    @(negedge HCLK); HRESET = 1'b0;
    read_check("rst_mid_stat", 2'd1, 32'h02);
    read_check("rst_mid_div", 2'd2, 32'd433);
    count_low(60, lows);
    check("rst_mid_no_tx", lows, 0);

    // Randomized RX/TX against a flag-level model
    bus_write(2'd2, 32'd4);
    rx_send(8'h3C, 1'b1, 4);
    read_check("rand_seed_byte", 2'd0, 32'h3C);
    m_byte = 8'h3C; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    for (int it = 0; it < 24; it++) begin
      d = $urandom_range(3, 8);
      bus_write(2'd2, 32'(d));
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          rb = 8'($urandom);
          bus_write(2'd0, {24'b0, rb});
          tx_expect(rb, d, $sformatf("rand_tx%0d", it));
          repeat (d + 3) @(posedge HCLK);
        end
        1, 2: begin
          rb = 8'($urandom);
          rs = ($urandom_range(0, 3) != 0);
          rx_send(rb, rs, d);
          if (!rs) m_ferr = 1'b1;
          else if (m_valid) m_ovr = 1'b1;
          else begin
            m_byte = rb;
            m_valid = 1'b1;
          end
        end
        3: begin
          read_check($sformatf("rand_data%0d", it), 2'd0, {24'b0, m_byte});
          m_valid = 1'b0;
        end
        default: begin
          read_check($sformatf("rand_stat%0d", it), 2'd1,
                     {26'b0, m_ferr, m_ovr, 1'b0, m_valid, 1'b1, 1'b0});
          m_ovr = 1'b0;
          m_ferr = 1'b0;
        end
      endcase
    end

`ifdef MFP_UART_LOOPBACK_EN
    bus_write(2'd2, 32'd3);
    read_check("lb_pre_data_flush", 2'd0, {24'b0, m_byte});
    bus_write(2'd3, 32'd1);
    bus_write(2'd0, 32'h7E);
    count_low(70, lows);
    check("lb_tx_held_high", lows, 0);
    read_check("lb_data_7e", 2'd0, 32'h7E);
    bus_write(2'd3, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
